counter_seq_checker: RTL
========================

Name: counter_seq_checker

Overview:
- Receiver-side companion to the free-running 32-bit up-counter source.
- Consumes a sampled counter stream (value plus valid strobe) and checks that each value is the previous value + 1, modulo 2^WIDTH.
- Locks onto the stream, detects skips, stalls and restarts, and reports status to the mixed-signal test harness.
- Sits between the NGHDL digital bridge and the testbench monitors.

Parameters:
- WIDTH, 32: width of the checked counter value.
- LOCK_COUNT, 4: consecutive correct increments required to enter LOCKED.
- ERR_CNT_W, 16: width of the error counter, which saturates.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, synchronous, active-low.
- in_valid  in  1  in_data is a new sample this cycle.
- in_data  in  WIDTH  sampled counter value.
- locked  out  1  checker is in LOCKED state.
- seq_err  out  1  one-cycle pulse: mismatch detected while LOCKED.
- restart  out  1  one-cycle pulse: in_data==0 received while LOCKED (source reset seen).
- expected  out  WIDTH  next expected value (last accepted value + 1).
- err_cnt  out  ERR_CNT_W  saturating count of seq_err pulses.

Behaviour:
- Reset:
  - Active when rstn==0 at a clk rising edge.
  - Clears the state to IDLE and sets expected=0, locked=0, seq_err=0, restart=0, err_cnt=0, match_run=0.
  - Reset asserted mid-operation overrides all other activity in that cycle.
- States are IDLE, ACQUIRE, LOCKED and ERROR. Transitions happen only on cycles with in_valid=1. When in_valid=0, state, expected and the counters hold, and the pulses are 0.
- IDLE: the first valid sample sets expected=in_data+1 and match_run=0, and moves to ACQUIRE.
- ACQUIRE:
  - Match (in_data==expected): match_run+1.
  - Mismatch: match_run=0 and stay in ACQUIRE.
  - Either way, expected=in_data+1.
  - On the match that makes match_run==LOCK_COUNT, move to LOCKED. locked rises on the following cycle.
  - No seq_err is raised in ACQUIRE.
- LOCKED:
  - Match: expected=in_data+1.
  - in_data==0 and expected!=0: restart=1 for one cycle, expected=1, move to ACQUIRE with match_run=0. This is not an error.
  - Any other mismatch: seq_err=1 for one cycle, err_cnt+1 (saturating), expected=in_data+1, move to ERROR.
- ERROR:
  - Match: move to ACQUIRE with match_run=1.
  - Mismatch: seq_err=1 again, err_cnt+1, stay in ERROR.
  - In both cases, expected=in_data+1.
- Arithmetic: expected wraps modulo 2^WIDTH. After the value all-ones, 0 is a match and is not reported as a restart.
- Repeated value (in_data==expected-1) while LOCKED is a mismatch and produces seq_err.
- Latency: every output is registered one cycle after the in_valid sample that caused it.
- err_cnt saturates at 2^ERR_CNT_W-1 and never wraps.

Optional Feature:
- Macro: COUNTER_SEQ_CHECKER_GAP_EN.
- Defined:
  - Adds output max_gap (WIDTH bits, reset 0).
  - max_gap holds the largest (in_data - expected) mod 2^WIDTH seen on any seq_err event, updated in the same cycle as seq_err.
- Undefined:
  - No max_gap port and no gap logic.
  - All other behaviour is identical.

Decomposition:
- Package counter_seq_checker_pkg holds:
  - the state enum (IDLE, ACQUIRE, LOCKED, ERROR);
  - default-width constants;
  - a function computing the wrapped next value.
- One sub-module, counter_seq_checker_satcnt: a parameterised saturating incrementer with enable and synchronous active-low clear. It is used for err_cnt and for match_run.

Test Plan:
1. Reset then stream 5,6,7,8,9 (valid every cycle):
   - locked=1 one cycle after sample 9;
   - expected=10;
   - seq_err never asserted.
2. Locked at expected=10, send 12:
   - seq_err pulse;
   - err_cnt=1;
   - state ERROR;
   - then 13,14,15,16 returns locked=1.
3. Locked, stream 0xFFFFFFFE, 0xFFFFFFFF, 0, 1:
   - no seq_err and no restart;
   - expected=2.
4. Locked at expected=100, send 0:
   - restart pulse, seq_err=0, err_cnt unchanged, locked drops;
   - 1,2,3,4 relocks.
5. Locked, deassert in_valid for 10 cycles, then send the expected value: no error and state held. Then assert rstn=0 for one cycle mid-stream: all outputs return to reset values.
6. ERR_CNT_W=2, hold in ERROR with 5 consecutive mismatches: err_cnt saturates at 3.
   - With COUNTER_SEQ_CHECKER_GAP_EN defined and expected=10: sending 15 then 40 gives max_gap=5, then 24 (40 is checked against expected 16).

Source files
------------

// File: rtl/counter_seq_checker_pkg.sv
// Shared types and helpers for the counter sequence checker.
// Optional feature macro used by the top: COUNTER_SEQ_CHECKER_GAP_EN.
package counter_seq_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_ERROR   = 2'd3
    } state_t;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_LOCK_COUNT = 4;
    localparam int DEF_ERR_CNT_W  = 16;

    // Value + 1 wrapped modulo 2^w, for any w up to 64.
    function automatic logic [63:0] wrap_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] mask;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v + 64'd1) & mask;
    endfunction

endpackage

// File: rtl/counter_seq_checker_satcnt.sv
// Saturating up-counter with enable and synchronous active-low clear.
// Clear and enable together load 1 (restart counting from this event).
module counter_seq_checker_satcnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr_n,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (!clr_n) begin
            cnt <= en ? W'(1) : '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/counter_seq_checker.sv
// Checks a sampled counter stream for +1 increments; locks, flags skips and restarts.
// Define COUNTER_SEQ_CHECKER_GAP_EN to add the max_gap output.
module counter_seq_checker
    import counter_seq_checker_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int ERR_CNT_W  = DEF_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 rstn,
    // in_valid is a pure strobe: no backpressure, every valid cycle is consumed.
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 locked,
    output logic                 seq_err,
    output logic                 restart,
    output logic [WIDTH-1:0]     expected,
    output logic [ERR_CNT_W-1:0] err_cnt,
`ifdef COUNTER_SEQ_CHECKER_GAP_EN
    output logic [WIDTH-1:0]     max_gap,
`endif
    output state_t               dbg_state
);

    localparam int MR_W = $clog2(LOCK_COUNT + 1);

    state_t            state;
    logic [MR_W-1:0]   match_run;
    logic [WIDTH-1:0]  next_exp;
    logic              match;
    logic              data_zero;
    logic              err_evt;
    logic              mr_en;
    logic              mr_clr_n;

    assign match     = (in_data == expected);
    assign data_zero = (in_data == '0);
    assign next_exp  = WIDTH'(wrap_inc(64'(in_data), WIDTH));
    assign err_evt   = in_valid && !match &&
                       ((state == ST_ERROR) || ((state == ST_LOCKED) && !data_zero));

    // match_run control: ERROR->ACQUIRE on a match uses clear+enable to land at 1.
    always_comb begin
        mr_en    = 1'b0;
        mr_clr_n = 1'b1;
        if (in_valid) begin
            case (state)
                ST_IDLE:    mr_clr_n = 1'b0;
                ST_ACQUIRE: begin
                    if (match) mr_en    = 1'b1;
                    else       mr_clr_n = 1'b0;
                end
                ST_LOCKED:  if (!match && data_zero) mr_clr_n = 1'b0;
                ST_ERROR:   begin
                    if (match) begin
                        mr_clr_n = 1'b0;
                        mr_en    = 1'b1;
                    end
                end
                default:    mr_clr_n = 1'b0;
            endcase
        end
    end

    counter_seq_checker_satcnt #(.W(MR_W)) u_match_run (
        .clk   (clk),
        .rstn  (rstn),
        .clr_n (mr_clr_n),
        .en    (mr_en),
        .cnt   (match_run)
    );

    counter_seq_checker_satcnt #(.W(ERR_CNT_W)) u_err_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr_n (1'b1),
        .en    (err_evt),
        .cnt   (err_cnt)
    );

`ifdef COUNTER_SEQ_CHECKER_GAP_EN
    logic [WIDTH-1:0] gap;
    assign gap = in_data - expected;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            expected <= '0;
            seq_err  <= 1'b0;
            restart  <= 1'b0;
`ifdef COUNTER_SEQ_CHECKER_GAP_EN
            max_gap  <= '0;
`endif
        end else begin
            seq_err <= 1'b0;
            restart <= 1'b0;
            if (in_valid) begin
                // Every branch, restart included (in_data==0 gives 1), reloads in_data+1.
                expected <= next_exp;
                case (state)
                    ST_IDLE:    state <= ST_ACQUIRE;
                    ST_ACQUIRE: begin
                        if (match && (match_run == MR_W'(LOCK_COUNT - 1))) state <= ST_LOCKED;
                    end
                    ST_LOCKED:  begin
                        if (!match) begin
                            if (data_zero) begin
                                restart <= 1'b1;
                                state   <= ST_ACQUIRE;
                            end else begin
                                seq_err <= 1'b1;
                                state   <= ST_ERROR;
                            end
                        end
                    end
                    ST_ERROR:   begin
                        if (match) state   <= ST_ACQUIRE;
                        else       seq_err <= 1'b1;
                    end
                    default:    state <= ST_IDLE;
                endcase
`ifdef COUNTER_SEQ_CHECKER_GAP_EN
                if (err_evt && (gap > max_gap)) max_gap <= gap;
`endif
            end
        end
    end

    assign locked    = (state == ST_LOCKED);
    assign dbg_state = state;

endmodule
